// File: rtl/demux_pkg.sv
// Shared types and default geometry for the 16-bit 1-to-16 registered demultiplexer.
package demux_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefLanes = 16;
  localparam int unsigned DefSelW  = 4;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL
  } state_e;

endpackage

// File: rtl/demux16bit_1to16_seq_if.sv
// Source-side/lane-side bundle for demux16bit_1to16_seq.
// DEMUX_READBACK_EN adds the Rsel/Rdata readback pair.
interface demux16bit_1to16_seq_if import demux_pkg::*; #(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned LANES = DefLanes,
  parameter int unsigned SEL_W = DefSelW
);

  logic                   E;
  logic                   Load;
  logic                   Auto;
  logic [SEL_W-1:0]       S;
  logic [WIDTH-1:0]       X;
  logic                   Clear;
  logic [LANES*WIDTH-1:0] Z;
  logic [LANES-1:0]       Valid;
  logic                   Ready;
  logic                   Done;
`ifdef DEMUX_READBACK_EN
  logic [SEL_W-1:0]       Rsel;
  logic [WIDTH-1:0]       Rdata;

  modport master (
    output E, Load, Auto, S, X, Clear, Rsel,
    input  Z, Valid, Ready, Done, Rdata
  );

  modport slave (
    input  E, Load, Auto, S, X, Clear, Rsel,
    output Z, Valid, Ready, Done, Rdata
  );
`else
  modport master (
    output E, Load, Auto, S, X, Clear,
    input  Z, Valid, Ready, Done
  );

  modport slave (
    input  E, Load, Auto, S, X, Clear,
    output Z, Valid, Ready, Done
  );
`endif

endinterface

// File: rtl/demux_lane_reg.sv
// One output lane: WIDTH-bit data register plus a written-since-clear flag.
// Clear drops the flag only; the data is retained.
module demux_lane_reg import demux_pkg::*; #(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (we_i) begin
      data_d  = d_i;
      valid_d = 1'b1;
    end
    if (clr_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q_o     = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/demux16bit_1to16_seq.sv
// Registered 1-to-16 demux: routes X to a lane by S or by an auto-incrementing frame pointer.
// Optional readback port enabled with DEMUX_READBACK_EN.
module demux16bit_1to16_seq import demux_pkg::*; #(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned LANES = DefLanes,
  parameter int unsigned SEL_W = DefSelW
) (
  input logic                   Clk,
  input logic                   Reset_n,
  demux16bit_1to16_seq_if.slave bus
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             done_q, done_d;
  logic             ready;
  logic             wr;
  logic [SEL_W-1:0] wr_sel;
  logic [LANES-1:0] we;
  logic [LANES-1:0] valid;
  logic [WIDTH-1:0] lane_q [LANES];
  logic [LANES*WIDTH-1:0] z;

  assign ready = (state_q != FULL);
  // Clear wins over a same-cycle Load, and a full frame stalls all writes.
  assign wr    = bus.E & bus.Load & ready & ~bus.Clear;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    wr_sel  = bus.Auto ? ptr_q : bus.S;
    if (bus.Clear) begin
      state_d = IDLE;
      ptr_d   = '0;
    end else if (wr && bus.Auto) begin
      if (ptr_q == SEL_W'(LANES - 1)) begin
        ptr_d   = '0;
        done_d  = 1'b1;
        state_d = FULL;
      end else begin
        ptr_d   = ptr_q + 1'b1;
        state_d = FILL;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    we = '0;
    if (wr) begin
      we[wr_sel] = 1'b1;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    demux_lane_reg #(
      .WIDTH (WIDTH)
    ) u_lane (
      .clk_i   (Clk),
      .rst_ni  (Reset_n),
      .we_i    (we[i]),
      .clr_i   (bus.Clear),
      .d_i     (bus.X),
      .q_o     (lane_q[i]),
      .valid_o (valid[i])
    );
  end

  always_comb begin
    z = '0;
    for (int i = 0; i < LANES; i++) begin
      z[i*WIDTH +: WIDTH] = lane_q[i];
    end
  end

  assign bus.Z     = z;
  assign bus.Valid = valid;
  assign bus.Ready = ready;
  assign bus.Done  = done_q;

`ifdef DEMUX_READBACK_EN
  // Reads the stored value; a write in the same cycle is not visible yet.
  assign bus.Rdata = lane_q[bus.Rsel];
`endif

endmodule
